// File: rtl/fpm_32_seq.sv
// Sequential binary32 multiplier: one mantissa bit per clock by shift-add,
// followed by a single normalise/round/special-case cycle.
//
// state | meaning
// IDLE  | waiting for Start; Product holds the last result
// MUL   | shift-add over 24 multiplier mantissa bits
// NORM  | normalise, round, select result, pulse Done
module fpm_32_seq #(
    parameter int          MANT_W      = 24,
    parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    output logic [31:0] Product,
    output logic        Busy,
    output logic        Done
);

    localparam int ACC_W = 2 * MANT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [MANT_W-1:0]  r_mant_a;
    logic [MANT_W-1:0]  r_mant_b;
    logic [ACC_W-1:0]   r_acc;
    logic [4:0]         r_count;

    logic [7:0]         w_exp_a;
    logic [7:0]         w_exp_b;
    logic               w_sign;
    logic               w_a_nan;
    logic               w_b_nan;
    logic               w_a_inf;
    logic               w_b_inf;
    logic               w_a_zero;
    logic               w_b_zero;
    logic [ACC_W-1:0]   w_addend;
    logic               w_p47;
    logic [22:0]        w_frac;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;
    logic [23:0]        w_frac_rnd;
    logic signed [9:0]  w_exp_norm;
    logic signed [9:0]  w_exp_fin;
    logic [31:0]        w_result;

    assign w_exp_a  = r_a[30:23];
    assign w_exp_b  = r_b[30:23];
    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_a_nan  = (&w_exp_a) & (|r_a[22:0]);
    assign w_b_nan  = (&w_exp_b) & (|r_b[22:0]);
    assign w_a_inf  = (&w_exp_a) & ~(|r_a[22:0]);
    assign w_b_inf  = (&w_exp_b) & ~(|r_b[22:0]);
    assign w_a_zero = (w_exp_a == 8'h00);
    assign w_b_zero = (w_exp_b == 8'h00);

    assign w_addend = {{MANT_W{1'b0}}, r_mant_a} << r_count;

    assign w_p47    = r_acc[ACC_W-1];
    assign w_frac   = w_p47 ? r_acc[46:24] : r_acc[45:23];
    assign w_guard  = w_p47 ? r_acc[23] : r_acc[22];
    assign w_sticky = w_p47 ? (|r_acc[22:0]) : (|r_acc[21:0]);
    assign w_inc    = w_guard & (w_sticky | w_frac[0]);

    // A carry out of the rounded fraction leaves its low 23 bits zero.
    assign w_frac_rnd = {1'b0, w_frac} + {23'd0, w_inc};
    assign w_exp_norm = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b})
                        - 10'sd127 + $signed({9'd0, w_p47});
    assign w_exp_fin  = w_exp_norm + $signed({9'd0, w_frac_rnd[23]});

    always_comb begin
        w_result = {w_sign, w_exp_fin[7:0], w_frac_rnd[22:0]};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            w_result = NAN_PATTERN;
        else if (w_a_inf || w_b_inf)
            w_result = {w_sign, 8'hFF, 23'd0};
        else if (w_a_zero || w_b_zero)
            w_result = {w_sign, 31'd0};
        else if (w_exp_fin >= 10'sd255)
            w_result = {w_sign, 8'hFF, 23'd0};
        else if (w_exp_fin <= 10'sd0)
            w_result = {w_sign, 31'd0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_mant_a <= '0;
            r_mant_b <= '0;
            r_acc    <= '0;
            r_count  <= 5'd0;
            Product  <= 32'd0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_a      <= Multiplicand;
                        r_b      <= Multiplier;
                        r_mant_a <= {(Multiplicand[30:23] != 8'h00), Multiplicand[22:0]};
                        r_mant_b <= {(Multiplier[30:23] != 8'h00), Multiplier[22:0]};
                        r_acc    <= '0;
                        r_count  <= 5'd0;
                        Busy     <= 1'b1;
                        r_state  <= MUL;
                    end
                end
                MUL: begin
                    if (r_mant_b[r_count])
                        r_acc <= r_acc + w_addend;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd23)
                        r_state <= NORM;
                end
                NORM: begin
                    Product <= w_result;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fpm_32_seq.md
Name: fpm_32_seq

Overview:
- Sequential IEEE-754 single-precision multiplier; the inverse-operation companion to the team's combinational 32-bit FP divider.
- Takes two 32-bit operands under a Start/Done handshake.
- Computes the 24x24 mantissa product with an iterative shift-add loop, one bit per clock, then normalises and rounds.
- Feeds the same FP datapath as the divider, where area matters more than latency.

Parameters:
- MANT_W, 24, mantissa width including hidden bit. Fixed at 24 for binary32; other values are unsupported.
- NAN_PATTERN, 32'h7FC00000, canonical quiet NaN emitted for all invalid results.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  request; sampled only when state is IDLE
- Multiplicand  input  32  operand A, binary32
- Multiplier  input  32  operand B, binary32
- Product  output  32  result, registered; held until next result
- Busy  output  1  high while an operation is in flight
- Done  output  1  one-cycle pulse; Product valid from this cycle on

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: state=IDLE, Product=0, Busy=0, Done=0, all internal registers cleared. Reset mid-operation aborts the operation; no Done is produced.
- FSM states:
  - IDLE: on an edge with Start=1, latch both operands and go to MUL; clear the 48-bit accumulator; set the bit counter to 0; Busy=1.
  - MUL: each edge, if multiplier-mantissa bit[count]=1, add (multiplicand-mantissa << count) to the accumulator; count++. After the edge where count=23, go to NORM.
  - NORM: one edge. Normalise, round, apply special cases, register Product, pulse Done=1, Busy=0, return to IDLE.
- Latency: Start sampled at edge E0 -> Done high for the single cycle following edge E25, a fixed 25 clocks for every operand class. Special cases still traverse MUL so latency stays constant.
- Start while Busy=1: ignored; latched operands are unaffected.
- Start=1 in the cycle Done=1: accepted, because the FSM is already in IDLE. Back-to-back throughput is one result per 26 cycles.
- Operand changes after E0 have no effect.
- Unpack:
  - sign = sA ^ sB.
  - Exponent field 0 (zero or subnormal) -> treated as signed zero (flush).
  - Hidden bit = 1 for normal operands.
- Normalise on the 48-bit product P:
  - If P[47]=1: frac=P[46:24], guard=P[23], sticky=|P[22:0], exp=eA+eB-126.
  - Else: frac=P[45:23], guard=P[22], sticky=|P[21:0], exp=eA+eB-127.
  - Exponent arithmetic is 10-bit signed; there is no wrap.
- Rounding: round-to-nearest-even. Increment when guard & (sticky | frac[0]). If frac overflows from all-ones, frac=0 and exp+1.
- Result selection, highest priority first:
  1. Either operand NaN, or inf*zero -> NAN_PATTERN.
  2. Either operand inf -> {sign, 8'hFF, 23'h0}.
  3. Either operand zero or subnormal -> {sign, 31'h0}.
  4. Final exp >= 255 -> {sign, 8'hFF, 23'h0}.
  5. Final exp <= 0 -> {sign, 31'h0} (flush, no subnormal output).
  6. Otherwise {sign, exp[7:0], frac}.
- Product changes only on the NORM edge or on reset.

Test Plan:
- Reset, then Start with Multiplicand=0x42B6B000 (91.34375) and Multiplier=0x3E140000 (0.14453125) -> Done exactly 25 clocks after the Start edge; Product=0x41533B80 (13.2020263671875); Busy high for E1..E25.
- Back-to-back: 0x3F800000 * 0x40000000 -> 0x40000000. Start held high in the Done cycle with 0x40000000 * 0x40A00000 -> second Done 26 cycles after the first; Product=0x41200000. Start pulses mid-operation are ignored.
- Sign and rounding: 0xC0000000 * 0x40A00000 -> 0xC1200000. 0x3F800001 * 0x3F800001 -> 0x3F800002 (sticky-only remainder rounds down).
- Specials, each at the 25-clock latency:
  - 0x7F000000 * 0x40000000 -> 0x7F800000 (overflow).
  - 0x7F800000 * 0x00000000 -> 0x7FC00000.
  - 0x00400000 (subnormal) * 0x3F800000 -> 0x00000000.
  - 0x00800000 * 0x00800000 -> 0x00000000 (underflow).
- Reset mid-operation: assert rst_n=0 at cycle 10 of an operation -> Busy=0, Done=0, Product=0 immediately, with no Done later. A new Start after release gives the correct result.
